fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 106 ++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, one-entry output register, BUBBLE/FETCH/HALT control.
// One cycle from PC to if_*; id_ready=0 holds pc and output register with zero-latency backpressure.
module fetch_unit #(
  parameter int WIDTH = 32,
  parameter int N = 6,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rd,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             halt_req,
  input  logic             resume,
  input  logic             id_ready,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_instr,
  output logic [WIDTH-1:0] if_pc,
  output logic [WIDTH-1:0] if_pc_plus4,
  output logic             misalign_err,
  output logic             range_err,
  output logic [WIDTH-1:0] fetch_count
);

  typedef enum logic [1:0] {
    BUBBLE = 2'd0,
    FETCH  = 2'd1,
    HALT   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic             redirect_ok;
  logic             pc_oor;
  logic             slot_free;
  logic             do_load;
  logic             set_range;

  assign imem_addr   = pc;
  assign pc_plus4    = pc + {{(WIDTH-3){1'b0}}, 3'd4};
  // A misaligned target is dropped entirely; only the sticky flag records it.
  assign redirect_ok = redirect && (redirect_pc[1:0] == 2'b00);
  assign pc_oor      = |pc[WIDTH-1:N+2];
  assign slot_free   = !if_valid || id_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BUBBLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    set_range = 1'b0;
    case (state)
      BUBBLE: state_nxt = FETCH;
      FETCH: begin
        if (!redirect_ok) begin
          if (halt_req) begin
            state_nxt = HALT;
          end else if (slot_free) begin
            if (pc_oor) set_range = 1'b1;
            else        do_load   = 1'b1;
          end
        end
      end
      HALT: begin
        // A redirect while halted only retargets the pc; fetching stays off.
        if (!redirect_ok && resume) state_nxt = FETCH;
      end
      default: state_nxt = BUBBLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      if_valid     <= 1'b0;
      if_instr     <= '0;
      if_pc        <= '0;
      if_pc_plus4  <= '0;
      misalign_err <= 1'b0;
      range_err    <= 1'b0;
      fetch_count  <= '0;
    end else begin
      if (redirect && !redirect_ok) misalign_err <= 1'b1;
      if (set_range)                range_err    <= 1'b1;
      if (redirect_ok) begin
        pc       <= redirect_pc;
        if_valid <= 1'b0;
      end else if (do_load) begin
        if_instr    <= imem_rd;
        if_pc       <= pc;
        if_pc_plus4 <= pc_plus4;
        if_valid    <= 1'b1;
        pc          <= pc_plus4;
        fetch_count <= fetch_count + {{(WIDTH-1){1'b0}}, 1'b1};
      end else if (id_ready) begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule
